// File: rtl/uart_tx.sv
// UART transmit serializer: start, DATA_BITS data (LSB first), optional parity, STOP_BITS stop; one bit per baud_en.
// Line goes low the cycle after accept; o_ready is high only in IDLE, so upstream is held off for the whole frame.
module uart_tx #(
    parameter int DATA_BITS  = 8,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_valid,
    input  logic [DATA_BITS-1:0] i_data,
    output logic                 o_ready,
    input  logic                 baud_en,
    output logic                 o_run,
    output logic                 o_baud_clr,
    output logic                 o_tx,
    output logic                 o_busy,
    output logic                 o_done
);

    localparam int CW = $clog2(DATA_BITS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t               state_q, state_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [CW-1:0]        bit_cnt_q, bit_cnt_d;
    logic                 stop_cnt_q, stop_cnt_d;
    logic                 par_q, par_d;
    logic                 tx_q, tx_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 accept;

    assign o_ready    = (state_q == S_IDLE);
    assign accept     = i_valid & o_ready;
    // Clearing the generator on accept keeps every frame bit-aligned to this block.
    assign o_baud_clr = accept;
    assign o_tx       = tx_q;
    assign o_run      = busy_q;
    assign o_busy     = busy_q;
    assign o_done     = done_q;

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        stop_cnt_d = stop_cnt_q;
        par_d      = par_q;
        tx_d       = tx_q;
        done_d     = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                tx_d = 1'b1;
                if (accept) begin
                    shift_d    = i_data;
                    par_d      = (^i_data) ^ (PARITY_ODD != 0);
                    bit_cnt_d  = '0;
                    stop_cnt_d = 1'b0;
                    tx_d       = 1'b0;
                    state_d    = S_START;
                end
            end
            S_START: begin
                if (baud_en) begin
                    tx_d    = shift_q[0];
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (baud_en) begin
                    shift_d = {1'b0, shift_q[DATA_BITS-1:1]};
                    if (bit_cnt_q == CW'(DATA_BITS - 1)) begin
                        state_d = (PARITY_EN != 0) ? S_PARITY : S_STOP;
                        tx_d    = (PARITY_EN != 0) ? par_q : 1'b1;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                        tx_d      = shift_d[0];
                    end
                end
            end
            S_PARITY: begin
                if (baud_en) begin
                    tx_d    = 1'b1;
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                tx_d = 1'b1;
                if (baud_en) begin
                    if (stop_cnt_q == 1'(STOP_BITS - 1)) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        stop_cnt_d = stop_cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                tx_d    = 1'b1;
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            stop_cnt_q <= 1'b0;
            par_q      <= 1'b0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            stop_cnt_q <= stop_cnt_d;
            par_q      <= par_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

endmodule
